// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
// Optional multi-word bursts are enabled by the FIFO_ARB_BURST_EN macro.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 4;
  localparam int DEF_MAX_BURST  = 4;

  // Owner index width; a single requester still needs a one-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Requester/FIFO-side bundle of the write arbiter: requests, data, full flag and the
// arbiter's grant/ack/write strobe. The arbiter connects through the slave modport.
interface fifo_write_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 4
);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic                          full;
  logic [NUM_REQ-1:0]            grant;
  logic [NUM_REQ-1:0]            ack;
  logic                          write_increment;
  logic [DATA_WIDTH-1:0]         write_data;

  modport master (
    output req, req_data, full,
    input  grant, ack, write_increment, write_data
  );

  modport slave (
    input  req, req_data, full,
    output grant, ack, write_increment, write_data
  );

endinterface

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after last_owner+1,
// wrapping around; returns a one-hot pick and its index.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_owner,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   pick_idx
);

  logic             found;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    cand_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_idx = IDX_W'((int'(last_owner) + 1 + i) % NUM_REQ);
      if (!found && req[cand_idx]) begin
        found          = 1'b1;
        pick[cand_idx] = 1'b1;
        pick_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
// Define FIFO_ARB_BURST_EN to allow up to MAX_BURST words per grant; otherwise one word per grant.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic                clk,
  input  logic                rst_n,
  fifo_write_arbiter_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_REQ);

  arb_state_t           state_reg, state_next;
  logic [NUM_REQ-1:0]   grant_reg, grant_next;
  logic [IDX_W-1:0]     owner_reg, owner_next;
  logic [IDX_W-1:0]     last_owner_reg, last_owner_next;

  logic [NUM_REQ-1:0]   pick;
  logic [IDX_W-1:0]     pick_idx;
  logic                 accept;
  logic                 burst_done;
  logic                 release_now;

  logic [DATA_WIDTH-1:0] slice [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign slice[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req        (bus.req),
    .last_owner (last_owner_reg),
    .pick       (pick),
    .pick_idx   (pick_idx)
  );

  // Reset is gated in so nothing is written while rst_n is low, even mid-burst.
  assign accept = rst_n && (state_reg == BUSY) && bus.req[owner_reg] && !bus.full;

`ifdef FIFO_ARB_BURST_EN
  logic [3:0] burst_cnt_reg, burst_cnt_next;

  assign burst_done = accept && ((burst_cnt_reg + 4'd1) == 4'(MAX_BURST));
`else
  // Single-word grants: the configured burst length collapses to one.
  localparam int BURST_LIMIT = (MAX_BURST < 1) ? MAX_BURST : 1;

  assign burst_done = accept && (BURST_LIMIT == 1);
`endif

  assign release_now = (state_reg == BUSY) && (!bus.req[owner_reg] || burst_done);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      owner_reg      <= '0;
      last_owner_reg <= IDX_W'(NUM_REQ - 1);
`ifdef FIFO_ARB_BURST_EN
      burst_cnt_reg  <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      owner_reg      <= owner_next;
      last_owner_reg <= last_owner_next;
`ifdef FIFO_ARB_BURST_EN
      burst_cnt_reg  <= burst_cnt_next;
`endif
    end
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    owner_next      = owner_reg;
    last_owner_next = last_owner_reg;
`ifdef FIFO_ARB_BURST_EN
    burst_cnt_next  = burst_cnt_reg;
`endif
    unique case (state_reg)
      IDLE: begin
        grant_next = '0;
        if (|bus.req) begin
          state_next = BUSY;
          grant_next = pick;
          owner_next = pick_idx;
        end
      end
      BUSY: begin
        if (release_now) begin
          state_next      = IDLE;
          grant_next      = '0;
          last_owner_next = owner_reg;
`ifdef FIFO_ARB_BURST_EN
          burst_cnt_next  = '0;
`endif
        end
`ifdef FIFO_ARB_BURST_EN
        else if (accept) begin
          burst_cnt_next = burst_cnt_reg + 4'd1;
        end
`endif
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  assign bus.grant           = grant_reg;
  assign bus.write_increment = accept;
  assign bus.ack             = accept ? grant_reg : '0;
  assign bus.write_data      = accept ? slice[owner_reg] : '0;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: directed steps plus randomized traffic
// compared every cycle against a transaction-level round-robin model.
module tb_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int MB = 4;
`ifdef FIFO_ARB_BURST_EN
  localparam int EFF = MB;
`else
  localparam int EFF = 1;
`endif

  logic clk;
  logic rst_n;

  fifo_write_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

  fifo_write_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Stimulus
  logic [N-1:0]    req_v;
  logic [N*DW-1:0] data_v;
  logic            full_v;
  logic            rst_v;

  // Reference model: current owner (-1 when no one holds the port), words written, last owner
  int m_owner;
  int m_words;
  int m_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    bit acc;
    acc = rst_v && (m_owner >= 0) && req_v[m_owner] && !full_v;
    if (!rst_v) begin
      m_owner = -1;
      m_words = 0;
      m_last  = N - 1;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (m_owner < 0 && req_v[c]) m_owner = c;
      end
      m_words = 0;
    end else begin
      if (acc) m_words++;
      if (!req_v[m_owner] || (acc && m_words == EFF)) begin
        m_last  = m_owner;
        m_owner = -1;
        m_words = 0;
      end
    end
  endtask

  task automatic step();
    bit              acc;
    logic [N-1:0]    exp_grant;
    logic [DW-1:0]   exp_data;
    @(negedge clk);
    rst_n        = rst_v;
    bus.req      = req_v;
    bus.req_data = data_v;
    bus.full     = full_v;
    #1;
    acc       = rst_v && (m_owner >= 0) && req_v[m_owner] && !full_v;
    exp_grant = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    exp_data  = acc ? data_v[m_owner*DW +: DW] : '0;
    chk("grant", 32'(bus.grant), 32'(exp_grant));
    chk("write_increment", 32'(bus.write_increment), 32'(acc));
    chk("ack", 32'(bus.ack), acc ? 32'(exp_grant) : 32'd0);
    chk("write_data", 32'(bus.write_data), 32'(exp_data));
    if (acc) $display("[TB] t=%0t write owner=%0d data=%h", $time, m_owner, exp_data);
    model_update();
  endtask

  initial begin
    m_owner = -1;
    m_words = 0;
    m_last  = N - 1;

    // Reset with all requesters asserting: nothing may be written or granted
    rst_v = 1'b0; req_v = '1; data_v = 16'h1234; full_v = 1'b0;
    rst_n = 1'b0; bus.req = req_v; bus.req_data = data_v; bus.full = full_v;
    @(posedge clk);
    repeat (2) step();

    // Single requester 0 with data 0xA
    rst_v = 1'b1; req_v = 4'b0001; data_v = 16'h000A;
    repeat (3) step();
    req_v = '0;
    repeat (2) step();

    // All requesters held: round-robin order with a dead cycle between grants
    req_v = '1; data_v = 16'hDCBA;
    repeat (24) step();

    // Full asserted for three cycles while a requester owns the port
    full_v = 1'b1;
    repeat (3) step();
    full_v = 1'b0;
    repeat (6) step();

    // Owner drops its request; then two requesters alternate
    req_v = 4'b0010;
    repeat (3) step();
    req_v = '0;
    repeat (2) step();
    req_v = 4'b0011;
    repeat (12) step();

    // Reset in the middle of traffic, then restart
    rst_v = 1'b0;
    step();
    rst_v = 1'b1; req_v = '1;
    repeat (4) step();

    // Randomized traffic with sticky requests, random full and rare resets
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(7) == 0) req_v[b] = ~req_v[b];
      end
      data_v = N*DW'($urandom);
      full_v = ($urandom_range(3) == 0);
      rst_v  = ($urandom_range(63) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing the FIFO write port.
REQ-002 SHALL have parameter DATA_WIDTH, default 4: FIFO word width.
REQ-003 SHALL have parameter MAX_BURST, default 4: maximum words per grant, range 1..15.
REQ-004 SHALL have port clk, input, 1 bit: FIFO write clock; one clock, all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port req, input, NUM_REQ bits: requester n has a word ready on req_data.
REQ-007 SHALL have port req_data, input, NUM_REQ*DATA_WIDTH bits: word of requester n in slice n.
REQ-008 SHALL have port full, input, 1 bit: FIFO full flag, write domain.
REQ-009 SHALL have port grant, output, NUM_REQ bits: registered, one-hot or zero, current owner.
REQ-010 SHALL have port ack, output, NUM_REQ bits: word of requester n consumed this cycle.
REQ-011 SHALL have port write_increment, output, 1 bit: FIFO write strobe.
REQ-012 SHALL have port write_data, output, DATA_WIDTH bits: FIFO write word.

Function
REQ-013 SHALL implement states IDLE and BUSY.
REQ-014 In IDLE with req nonzero, SHALL pick a round-robin owner, searching from last_owner+1 upward with wrap-around, register grant one-hot, and enter BUSY next cycle.
REQ-015 In IDLE with req zero, SHALL stay in IDLE with grant=0.
REQ-016 Accept = BUSY & req[owner] & !full; on accept, write_increment=1, ack[owner]=1, write_data=owner slice, all combinational in the same cycle.
REQ-017 When not accepting, write_increment, ack and write_data SHALL be 0.
REQ-018 SHALL increment the 4-bit burst_cnt on each accept; while full=1, the count and grant SHALL hold.
REQ-019 In BUSY, SHALL release to IDLE and clear grant at the next edge when req[owner]=0, or when an accept brings burst_cnt to MAX_BURST.
REQ-020 On release, last_owner SHALL be set to owner and burst_cnt cleared.
REQ-021 Each release SHALL cost exactly one IDLE cycle; back-to-back bursts from any requesters SHALL be separated by one dead cycle.
REQ-022 Requests from non-owners SHALL be ignored while in BUSY; no preemption.

Reset
REQ-023 With rst_n=0 at an edge, SHALL go to IDLE with grant=0, burst_cnt=0 and last_owner=NUM_REQ-1, so that requester 0 wins first.
REQ-024 Reset mid-burst SHALL drop the burst immediately, with no further write_increment.
REQ-025 During reset, write_increment and ack SHALL be 0 regardless of req.

Configuration
REQ-026 Macro FIFO_ARB_BURST_EN: when defined, bursts up to MAX_BURST apply per REQ-019.
REQ-027 When FIFO_ARB_BURST_EN is undefined, the effective MAX_BURST SHALL be 1 (one word per grant), and burst_cnt logic SHALL be removed.

Structure
REQ-028 Package fifo_arb_pkg SHALL hold the state enum (IDLE, BUSY) and the default NUM_REQ/DATA_WIDTH/MAX_BURST constants.
REQ-029 Sub-module rr_pick SHALL be combinational: inputs req and last_owner; outputs a one-hot pick and its index.

Verification
REQ-030 Reset then req=0001, data0=0xA, full=0 -> grant=0001 at cycle 2, write_increment with write_data=0xA at cycle 2, ack[0]=1.
REQ-031 req=1111 held, burst enabled, MAX_BURST=4 -> owners 0,1,2,3,0 in order; 4 writes each; one idle cycle between bursts.
REQ-032 Owner 2 in BUSY, full=1 for 3 cycles -> no write, grant holds 0100, burst_cnt unchanged; writes resume when full=0.
REQ-033 Owner 1 drops req after 2 words -> release next edge, grant=0; next pick starts at requester 2.
REQ-034 rst_n=0 mid-burst -> next edge grant=0, write_increment=0; after release from reset, requester 0 wins.
REQ-035 FIFO_ARB_BURST_EN undefined, req=0011 -> single-word grants alternating 0,1,0,1.
